// File: rtl/aes_ctrl_pkg.sv
// aes_ctrl_pkg: shared FSM state type and counter sizing for the AES core scheduler
package aes_ctrl_pkg;

    typedef enum logic [2:0] {IDLE, SETTLE, ISSUE, WAIT, RESP} state_t;

    function automatic int cnt_w(input int settle, input int timeout);
        return $clog2((settle > timeout ? settle : timeout) + 1);
    endfunction

endpackage

// File: rtl/aes_rr_arbiter.sv
// aes_rr_arbiter: combinational round-robin pick, searching upward from ptr with wrap
module aes_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx
);

    logic          hit;
    logic [IW-1:0] j;

    // walk candidates from farthest to nearest so the nearest requester wins
    always_comb begin
        idx = '0;
        hit = 1'b0;
        j   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = IW'((int'(ptr) + k) % NREQ);
            if (req[j]) begin
                idx = j;
                hit = 1'b1;
            end
        end
        grant = hit ? NREQ'(1) << idx : '0;
    end

endmodule

// File: rtl/aes_core_sched.sv
// aes_core_sched: shares one AES core among NREQ requesters with key settle and watchdog
module aes_core_sched
    import aes_ctrl_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int Nk         = 4,
    parameter int KEY_SETTLE = 16,
    parameter int TIMEOUT    = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [128*NREQ-1:0]  req_pt,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [127:0]         rsp_ct,
    output logic                 rsp_err,
    input  logic                 key_wr,
    input  logic [32*Nk-1:0]     key_in,
    output logic                 key_ready,
    output logic [32*Nk-1:0]     core_key,
    output logic                 core_load,
    output logic [127:0]         core_pt,
    input  logic [127:0]         core_ct,
    input  logic                 core_valid,
    output logic                 err_timeout
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = cnt_w(KEY_SETTLE, TIMEOUT);

    state_t          state;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   gid;
    logic [IW-1:0]   g_idx;
    logic [NREQ-1:0] g_oh;
    logic [CW-1:0]   cnt;
    logic [32*Nk-1:0] shadow;
    logic            key_pending;
    logic            hs;
    logic [127:0]    pt_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_pt
        assign pt_arr[i] = req_pt[128*i +: 128];
    end

    aes_rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (g_oh),
        .idx   (g_idx)
    );

    // grants only when idle with no key update waiting, and never during reset
    assign req_ready = (state == IDLE && !key_pending && !rst) ? g_oh : '0;
    assign hs        = |(req_valid & req_ready);

    // scheduler FSM; one down-counter serves both key settle and the block watchdog
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            gid         <= '0;
            cnt         <= '0;
            shadow      <= '0;
            key_pending <= 1'b0;
            key_ready   <= 1'b1;
            core_key    <= '0;
            core_load   <= 1'b0;
            core_pt     <= '0;
            rsp_valid   <= '0;
            rsp_ct      <= '0;
            rsp_err     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            core_load <= 1'b0;
            if (key_wr && key_ready) begin
                shadow      <= key_in;
                key_pending <= 1'b1;
                key_ready   <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (key_pending) begin
                        core_key <= shadow;
                        cnt      <= CW'(KEY_SETTLE);
                        state    <= SETTLE;
                    end else if (hs) begin
                        core_pt   <= pt_arr[g_idx];
                        gid       <= g_idx;
                        core_load <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                SETTLE: begin
                    if (cnt == '0) begin
                        key_pending <= 1'b0;
                        key_ready   <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ISSUE: begin
                    cnt   <= CW'(TIMEOUT - 1);
                    state <= WAIT;
                end
                WAIT: begin
                    if (core_valid) begin
                        rsp_ct    <= core_ct;
                        rsp_err   <= 1'b0;
                        rsp_valid <= NREQ'(1) << gid;
                        state     <= RESP;
                    end else if (cnt == '0) begin
                        rsp_ct      <= '0;
                        rsp_err     <= 1'b1;
                        err_timeout <= 1'b1;
                        rsp_valid   <= NREQ'(1) << gid;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready[gid]) begin
                        rsp_valid <= '0;
                        rr_ptr    <= IW'((int'(gid) + 1) % NREQ);
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_core_sched.sv
// tb_aes_core_sched: directed checks of arbitration, key settle, watchdog, backpressure and reset
module tb_aes_core_sched;

    localparam int NREQ = 4;
    localparam int Nk   = 4;
    localparam logic [127:0] K0   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P0   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT0  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K2   = 128'hdeadbeef0123456789abcdeffedcba98;
    localparam logic [127:0] MASK = 128'ha5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [128*NREQ-1:0] req_pt = '0;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ-1:0]     rsp_valid;
    logic [NREQ-1:0]     rsp_ready = '0;
    logic [127:0]        rsp_ct;
    logic                rsp_err;
    logic                key_wr = 1'b0;
    logic [32*Nk-1:0]    key_in = '0;
    logic                key_ready;
    logic [32*Nk-1:0]    core_key;
    logic                core_load;
    logic [127:0]        core_pt;
    logic [127:0]        core_ct;
    logic                core_valid;
    logic                err_timeout;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int loads = 0;
    int pulse_bad = 0;
    int cv_cyc = 0;
    int load_cyc = 0;
    int valid_cyc = 0;
    int rsp_cyc = 0;
    int core_lat = 5;
    bit withhold = 1'b0;
    bit prev_load = 1'b0;

    aes_core_sched #(.NREQ(NREQ), .Nk(Nk), .KEY_SETTLE(16), .TIMEOUT(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_pt     (req_pt),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_ct     (rsp_ct),
        .rsp_err    (rsp_err),
        .key_wr     (key_wr),
        .key_in     (key_in),
        .key_ready  (key_ready),
        .core_key   (core_key),
        .core_load  (core_load),
        .core_pt    (core_pt),
        .core_ct    (core_ct),
        .core_valid (core_valid),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // stand-in cipher: the FIPS-197 vector for its own key/pt pair, otherwise a keyed xor
    function automatic logic [127:0] fm(input logic [127:0] k, input logic [127:0] p);
        return (k == K0 && p == P0) ? CT0 : (p ^ k ^ MASK);
    endfunction

    logic [127:0] m_key, m_pt;
    logic [7:0]   lat_cnt;
    logic         busy;

    // core model: one block in flight, answers core_lat cycles after load unless withheld
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy       <= 1'b0;
            core_valid <= 1'b0;
            core_ct    <= '0;
            lat_cnt    <= '0;
        end else begin
            core_valid <= 1'b0;
            if (core_load) begin
                busy    <= 1'b1;
                lat_cnt <= 8'd1;
                m_key   <= core_key;
                m_pt    <= core_pt;
            end else if (busy) begin
                if (int'(lat_cnt) >= core_lat) begin
                    busy <= 1'b0;
                    if (!withhold) begin
                        core_valid <= 1'b1;
                        core_ct    <= fm(m_key, m_pt);
                    end
                end else begin
                    lat_cnt <= lat_cnt + 8'd1;
                end
            end
        end
    end

    // pulse-width and timing monitor for core_load / core_valid
    always @(negedge clk) begin
        if (core_load) loads++;
        if (core_load && prev_load) pulse_bad++;
        prev_load = core_load;
        if (core_valid) cv_cyc = cyc;
    end

    task automatic do_key(input logic [127:0] k);
        int n = 0;
        while (!key_ready && n < 100) begin @(negedge clk); n++; end
        if (!key_ready) begin
            checks++; errors++;
            $display("FAIL key_wait: key_ready=%b required 1", key_ready);
        end
        key_in = k;
        key_wr = 1'b1;
        @(negedge clk);
        key_wr = 1'b0;
    endtask

    task automatic send(input int i, input logic [127:0] pt);
        int n = 0;
        req_pt[128*i +: 128] = pt;
        req_valid[i] = 1'b1;
        #1;
        while (!req_ready[i] && n < 300) begin @(negedge clk); #1; n++; end
        if (!req_ready[i]) begin
            checks++; errors++;
            $display("FAIL grant_wait req%0d: req_ready=%b required bit set", i, req_ready);
        end
        @(negedge clk);
        req_valid[i] = 1'b0;
        load_cyc = cyc;
    endtask

    task automatic recv(input int i, output logic [127:0] ct, output logic err);
        int n = 0;
        while (!rsp_valid[i] && n < 300) begin @(negedge clk); n++; end
        if (!rsp_valid[i]) begin
            checks++; errors++;
            $display("FAIL rsp_wait req%0d: rsp_valid=%b required bit set", i, rsp_valid);
        end
        valid_cyc = cyc;
        ct = rsp_ct;
        err = rsp_err;
        rsp_ready[i] = 1'b1;
        @(negedge clk);
        rsp_ready[i] = 1'b0;
        rsp_cyc = cyc;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        req_valid = 4'hf;
        repeat (2) @(negedge clk);
        checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL rst_req_ready: got %b required 0000", req_ready); end
        checks++; if (rsp_valid !== 4'h0) begin errors++; $display("FAIL rst_rsp_valid: got %b required 0000", rsp_valid); end
        checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL rst_key_ready: got %b required 1", key_ready); end
        checks++; if (core_load !== 1'b0 || err_timeout !== 1'b0 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL rst_flags: load=%b tmo=%b err=%b required 0 0 0", core_load, err_timeout, rsp_err);
        end
        checks++; if (core_key !== '0 || rsp_ct !== '0 || core_pt !== '0) begin
            errors++; $display("FAIL rst_data: key=%h ct=%h pt=%h required zeros", core_key, rsp_ct, core_pt);
        end
        req_valid = '0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [127:0] ct;
        logic err;
        int l0;
        do_key(K0);
        checks++; if (key_ready !== 1'b0) begin errors++; $display("FAIL key_busy: got %b required 0", key_ready); end
        do_key(K0 ^ K0 ^ K0);
        checks++; if (core_key !== K0) begin errors++; $display("FAIL core_key: got %h required %h", core_key, K0); end
        l0 = loads;
        send(0, P0);
        checks++; if (core_load !== 1'b1) begin errors++; $display("FAIL load_after_hs: got %b required 1", core_load); end
        checks++; if (core_pt !== P0) begin errors++; $display("FAIL core_pt: got %h required %h", core_pt, P0); end
        recv(0, ct, err);
        checks++; if (ct !== CT0 || err !== 1'b0) begin errors++; $display("FAIL single_ct: got %h err=%b required %h err=0", ct, err, CT0); end
        checks++; if (loads - l0 != 1 || pulse_bad != 0) begin errors++; $display("FAIL load_pulse: loads=%0d bad=%0d required 1 0", loads - l0, pulse_bad); end
        checks++; if (valid_cyc != cv_cyc + 1) begin errors++; $display("FAIL rsp_latency: got %0d required %0d", valid_cyc, cv_cyc + 1); end
    endtask

    task automatic test_round_robin();
        logic [127:0] ct;
        logic [127:0] pts [4];
        logic err;
        int g, n;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        core_lat = 3;
        for (int i = 0; i < 4; i++) begin
            pts[i] = {4{32'h1000_0000 * (i + 1) + 32'h0bad_c0de}};
            req_pt[128*i +: 128] = pts[i];
        end
        req_valid = 4'hf;
        for (int b = 0; b < 8; b++) begin
            n = 0;
            #1;
            while (req_ready == '0 && n < 100) begin @(negedge clk); #1; n++; end
            g = 0;
            for (int i = 0; i < 4; i++) if (req_ready[i]) g = i;
            checks++; if (!$onehot(req_ready)) begin errors++; $display("FAIL rr_onehot b%0d: got %b required one-hot", b, req_ready); end
            checks++; if (g != b % 4) begin errors++; $display("FAIL rr_order b%0d: got %0d required %0d", b, g, b % 4); end
            @(negedge clk);
            recv(g, ct, err);
            checks++; if (ct !== fm('0, pts[g]) || err !== 1'b0) begin errors++; $display("FAIL rr_ct b%0d: got %h required %h", b, ct, fm('0, pts[g])); end
        end
        req_valid = '0;
    endtask

    task automatic test_key_mid_block();
        logic [127:0] ct;
        logic err;
        int low;
        low = 0;
        core_lat = 20;
        send(1, 128'h0f0e0d0c0b0a09080706050403020100);
        repeat (2) @(negedge clk);
        do_key(K1);
        checks++; if (key_ready !== 1'b0 || core_key !== '0) begin errors++; $display("FAIL key_deferred: ready=%b key=%h required 0 and old key 0", key_ready, core_key); end
        recv(1, ct, err);
        checks++; if (ct !== fm('0, 128'h0f0e0d0c0b0a09080706050403020100)) begin errors++; $display("FAIL old_key_ct: got %h", ct); end
        fork
            begin
                int m = 0;
                while (!key_ready && m < 100) begin low++; @(negedge clk); m++; end
            end
            send(2, 128'h3243f6a8885a308d313198a2e0370734);
        join
        checks++; if (low < 16) begin errors++; $display("FAIL settle_len: got %0d required >= 16", low); end
        checks++; if (load_cyc - rsp_cyc < 17) begin errors++; $display("FAIL settle_gap: got %0d required >= 17", load_cyc - rsp_cyc); end
        checks++; if (core_key !== K1) begin errors++; $display("FAIL new_key: got %h required %h", core_key, K1); end
        recv(2, ct, err);
        checks++; if (ct !== fm(K1, 128'h3243f6a8885a308d313198a2e0370734)) begin errors++; $display("FAIL new_key_ct: got %h required %h", ct, fm(K1, 128'h3243f6a8885a308d313198a2e0370734)); end
    endtask

    task automatic test_timeout();
        logic [127:0] ct;
        logic err;
        core_lat = 5;
        withhold = 1'b1;
        send(2, 128'h11111111222222223333333344444444);
        recv(2, ct, err);
        checks++; if (err !== 1'b1 || ct !== '0) begin errors++; $display("FAIL tmo_rsp: err=%b ct=%h required 1 and 0", err, ct); end
        checks++; if (valid_cyc - load_cyc != 65) begin errors++; $display("FAIL tmo_cycles: got %0d required 65", valid_cyc - load_cyc); end
        withhold = 1'b0;
        send(3, 128'h55555555666666667777777788888888);
        recv(3, ct, err);
        checks++; if (ct !== fm(K1, 128'h55555555666666667777777788888888) || err !== 1'b0) begin errors++; $display("FAIL post_tmo_ct: got %h err=%b", ct, err); end
        checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %b required 1", err_timeout); end
    endtask

    task automatic test_backpressure();
        logic [127:0] ct, ct0;
        logic err;
        int bad, n;
        bad = 0;
        n = 0;
        send(0, 128'hcafef00dcafef00dcafef00dcafef00d);
        while (!rsp_valid[0] && n < 100) begin @(negedge clk); n++; end
        ct0 = rsp_ct;
        checks++; if (ct0 !== fm(K1, 128'hcafef00dcafef00dcafef00dcafef00d)) begin errors++; $display("FAIL bp_ct: got %h", ct0); end
        req_pt[128 +: 128] = 128'h0123456789abcdef0123456789abcdef;
        req_valid[1] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            rsp_ready = (c >= 3 && c <= 6) ? 4'b1110 : 4'b0000;
            @(negedge clk);
            if (rsp_ct !== ct0 || rsp_valid !== 4'b0001 || req_ready !== 4'b0000) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold: %0d unstable cycles required 0", bad); end
        rsp_ready = 4'b0001;
        @(negedge clk);
        rsp_ready = '0;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_next_grant: got %b required 0010", req_ready); end
        @(negedge clk);
        req_valid[1] = 1'b0;
        recv(1, ct, err);
        checks++; if (ct !== fm(K1, 128'h0123456789abcdef0123456789abcdef)) begin errors++; $display("FAIL bp_second_ct: got %h", ct); end
    endtask

    task automatic test_reset_mid();
        int seen;
        seen = 0;
        core_lat = 30;
        send(2, 128'h99999999999999999999999999999999);
        repeat (3) @(negedge clk);
        do_key(K2);
        req_valid[0] = 1'b1;
        #3 rst = 1'b1;
        #1;
        checks++; if (rsp_valid !== '0 || req_ready !== '0 || core_load !== 1'b0) begin errors++; $display("FAIL rst_mid_out: rsp=%b rdy=%b load=%b required 0", rsp_valid, req_ready, core_load); end
        checks++; if (key_ready !== 1'b1 || err_timeout !== 1'b0 || core_key !== '0) begin errors++; $display("FAIL rst_mid_state: key_ready=%b tmo=%b key=%h required 1 0 0", key_ready, err_timeout, core_key); end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (rsp_valid !== '0) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL rst_dropped: rsp_valid seen %0d cycles required 0", seen); end
        checks++; if (key_ready !== 1'b1 || core_key !== '0) begin errors++; $display("FAIL rst_shadow: key_ready=%b key=%h required 1 and 0", key_ready, core_key); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_key_mid_block();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
